updown_counter_mod: RTL and testbench

- Parametrised up/down counter, successor to the fixed 4-bit up/down counter.
- Adds configurable width, programmable modulus, wrap-or-saturate policy, count enable, synchronous clear, parallel load and registered boundary flags.
- Used as a general timing/event counter by the surrounding control blocks.

---
 rtl/updown_counter_mod_pkg.sv | 10 +
 rtl/updown_counter_mod_next.sv | 55 +++++
 rtl/updown_counter_mod.sv | 62 ++++++
 tb/tb_updown_counter_mod.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_mod_pkg.sv
// Shared encodings for the parametrised up/down counter family.
package updown_pkg;

  localparam logic CNT_UP = 1'b0;
  localparam logic CNT_DN = 1'b1;

  localparam int POL_WRAP = 0;
  localparam int POL_SAT  = 1;

endpackage

// File: rtl/updown_counter_mod_next.sv
// Combinational next-count and boundary-event logic; priority clr > load > en.
module updown_next
  import updown_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int              SATURATE = POL_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_nxt,
  output logic             wrap_evt,
  output logic             sat_evt
);

  // One extra bit keeps the clamp compare meaningful when MAX_VAL is all ones.
  logic load_over;
  assign load_over = {1'b0, load_val} > {1'b0, MAX_VAL};

  always_comb begin
    count_nxt = count;
    wrap_evt  = 1'b0;
    sat_evt   = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_over ? MAX_VAL : load_val;
    end else if (en) begin
      if (mode == CNT_UP) begin
        if (count != MAX_VAL) begin
          count_nxt = count + WIDTH'(1);
        end else if (SATURATE == POL_WRAP) begin
          count_nxt = '0;
          wrap_evt  = 1'b1;
        end else begin
          sat_evt = 1'b1;
        end
      end else begin
        if (count != '0) begin
          count_nxt = count - WIDTH'(1);
        end else if (SATURATE == POL_WRAP) begin
          count_nxt = MAX_VAL;
          wrap_evt  = 1'b1;
        end else begin
          sat_evt = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter: programmable modulus, wrap or saturate policy,
// clear/load/enable, and registered boundary flags and event pulses.
module updown_counter_mod
  import updown_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               SATURATE = POL_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_evt;
  logic             sat_evt;

  updown_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .count     (count),
    .mode      (mode),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .count_nxt (count_nxt),
    .wrap_evt  (wrap_evt),
    .sat_evt   (sat_evt)
  );

  // Flags are derived from the next count so they stay aligned with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= RST_VAL;
      at_max <= (RST_VAL == MAX_VAL);
      at_min <= (RST_VAL == '0);
      wrap   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      count  <= count_nxt;
      at_max <= (count_nxt == MAX_VAL);
      at_min <= (count_nxt == '0);
      wrap   <= wrap_evt;
      sat    <= sat_evt;
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Randomised and directed bench for updown_counter_mod: a wrapping and a
// saturating instance share stimulus and are checked against integer models.
module tb_updown_counter_mod;

  localparam int MAXV = 9;
  localparam int RST_W = 3;
  localparam int RST_S = 0;

  logic       clk = 1'b0;
  logic       rst, en, mode, clr, load;
  logic [3:0] load_val;

  logic [3:0] count_w, count_s;
  logic       at_max_w, at_min_w, wrap_w, sat_w;
  logic       at_max_s, at_min_s, wrap_s, sat_s;

  int total = 0;
  int bad   = 0;

  int mc[2];
  int mw[2];
  int ms[2];

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd3), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .load(load),
    .load_val(load_val), .count(count_w), .at_max(at_max_w), .at_min(at_min_w),
    .wrap(wrap_w), .sat(sat_w)
  );

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd0), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .load(load),
    .load_val(load_val), .count(count_s), .at_max(at_max_s), .at_min(at_min_s),
    .wrap(wrap_s), .sat(sat_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mc[0] = RST_W; mc[1] = RST_S;
    mw[0] = 0; mw[1] = 0; ms[0] = 0; ms[1] = 0;
  endtask

  // Instance 0 counts modulo MAXV+1; instance 1 is clamped to [0, MAXV].
  task automatic model_step(input int i);
    int c;
    c = mc[i];
    mw[i] = 0;
    ms[i] = 0;
    if (clr) c = 0;
    else if (load) c = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
    else if (en) begin
      if (mode == 1'b0) begin
        if (i == 1) begin
          ms[i] = (c == MAXV);
          if (c < MAXV) c = c + 1;
        end else begin
          c = (c + 1) % (MAXV + 1);
          mw[i] = (c == 0);
        end
      end else begin
        if (i == 1) begin
          ms[i] = (c == 0);
          if (c > 0) c = c - 1;
        end else begin
          mw[i] = (c == 0);
          c = (c + MAXV) % (MAXV + 1);
        end
      end
    end
    mc[i] = c;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt_w"},  32'(count_w),  32'(mc[0]));
    chk({tag, ".max_w"},  32'(at_max_w), 32'(mc[0] == MAXV));
    chk({tag, ".min_w"},  32'(at_min_w), 32'(mc[0] == 0));
    chk({tag, ".wrap_w"}, 32'(wrap_w),   32'(mw[0]));
    chk({tag, ".sat_w"},  32'(sat_w),    32'(ms[0]));
    chk({tag, ".cnt_s"},  32'(count_s),  32'(mc[1]));
    chk({tag, ".max_s"},  32'(at_max_s), 32'(mc[1] == MAXV));
    chk({tag, ".min_s"},  32'(at_min_s), 32'(mc[1] == 0));
    chk({tag, ".wrap_s"}, 32'(wrap_s),   32'(mw[1]));
    chk({tag, ".sat_s"},  32'(sat_s),    32'(ms[1]));
  endtask

  // Drive inputs away from the edge, update the models on the edge, sample 1 ns later.
  task automatic step(input string tag, input logic e, input logic m, input logic c,
                      input logic l, input logic [3:0] lv);
    en = e; mode = m; clr = c; load = l; load_val = lv;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    #2;
    check_all("reset");
    chk("reset_const_w", 32'(count_w), 32'd3);
    @(negedge clk);
    rst = 1'b0;

    // Wrapping count-up through the full modulus from 0.
    step("clr0", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 9; k++) step("up", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("up_at9", 32'(count_w), 32'd9);
    chk("up_max9", 32'(at_max_w), 32'd1);
    step("upwrap", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("wrap_to0", 32'(count_w), 32'd0);
    chk("wrap_pulse", 32'(wrap_w), 32'd1);
    step("upafter", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("wrap_gone", 32'(wrap_w), 32'd0);

    // Down from 0 wraps to MAX_VAL, then descends.
    step("clr1", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step("dnwrap", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("dn_to9", 32'(count_w), 32'd9);
    chk("dn_wrap", 32'(wrap_w), 32'd1);
    for (int k = 0; k < 3; k++) step("dn", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("dn_at6", 32'(count_w), 32'd6);

    // Clamped load then saturation on the saturating instance.
    step("ld12", 1'b0, 1'b0, 1'b0, 1'b1, 4'd12);
    chk("clamp9", 32'(count_s), 32'd9);
    for (int k = 0; k < 3; k++) begin
      step("satup", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      chk("sat_hold", 32'(count_s), 32'd9);
      chk("sat_pulse", 32'(sat_s), 32'd1);
    end

    // Priority: clr beats load and en; load beats en.
    step("prio_clr", 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    chk("prio_clr0", 32'(count_w), 32'd0);
    step("prio_ld", 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    chk("prio_ld5", 32'(count_w), 32'd5);

    // Asynchronous reset between edges while counting, then resume.
    step("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    async_reset("arst");
    chk("arst_3", 32'(count_w), 32'd3);
    step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("resume4", 32'(count_w), 32'd4);

    // Enable/mode toggling from 4.
    step("ld4", 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
    step("tg1", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("tg_5a", 32'(count_w), 32'd5);
    step("tg2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("tg_5b", 32'(count_w), 32'd5);
    step("tg3", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("tg_4a", 32'(count_w), 32'd4);
    step("tg4", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("tg_4b", 32'(count_w), 32'd4);

    // Random traffic, biased towards enabled steps so both bounds are hit often.
    for (int k = 0; k < 600; k++) begin
      step("rnd",
           logic'($urandom_range(0, 9) < 8),
           logic'($urandom_range(0, 99) < (k % 200 < 100 ? 25 : 75)),
           logic'($urandom_range(0, 49) == 0),
           logic'($urandom_range(0, 19) == 0),
           4'($urandom_range(0, 15)));
      if ((k % 97) == 50) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
